hazard_controller: RTL

- Pipeline sequencing controller for the 5-stage RV32 core. Works alongside the combinational forwarding unit.
- Resolves the hazards that forwarding cannot cover: load-use stalls, taken-branch flushes, data-memory wait states and multi-cycle mul/div occupancy of EX.
- Drives PC-write, stage-register hold/flush controls and the mul/div start handshake.
- Keeps a saturating stall-cycle performance counter and a mul/div watchdog.

---
 rtl/hazard_if.sv | 64 ++++++
 rtl/hazard_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// -----------------------------------------------------------------------------
// hazard_if
//   Bundles the pipeline-facing signals of the hazard controller.
//
//   Pipeline -> controller (decode/execute/memory status):
//     rs1_id, rs2_id, uses_rs1_id, uses_rs2_id   source operands of ID instr
//     rd_ex, mem_read_ex, reg_write_ex           destination info of EX instr
//     branch_taken_ex                            EX redirected the PC
//     muldiv_ex, muldiv_done                     mul/div occupancy of EX
//     dmem_req_mem, dmem_ready                   data-memory handshake in MEM
//   Controller -> pipeline (sequencing controls):
//     pc_write, stall_*, flush_*                 stage register controls
//     muldiv_start                               start pulse to mul/div unit
//     muldiv_timeout, ctrl_state, stall_count    status / performance
//
//   Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             uses_rs1_id;
    logic             uses_rs2_id;
    logic [4:0]       rd_ex;
    logic             mem_read_ex;
    logic             reg_write_ex;
    logic             branch_taken_ex;
    logic             muldiv_ex;
    logic             muldiv_done;
    logic             dmem_req_mem;
    logic             dmem_ready;

    logic             pc_write;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             flush_mem_wb;
    logic             muldiv_start;
    logic             muldiv_timeout;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        output rd_ex, mem_read_ex, reg_write_ex, branch_taken_ex,
        output muldiv_ex, muldiv_done, dmem_req_mem, dmem_ready,
        input  pc_write, stall_if_id, stall_id_ex, stall_ex_mem,
        input  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
        input  muldiv_start, muldiv_timeout, ctrl_state, stall_count
    );

    modport slave (
        input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        input  rd_ex, mem_read_ex, reg_write_ex, branch_taken_ex,
        input  muldiv_ex, muldiv_done, dmem_req_mem, dmem_ready,
        output pc_write, stall_if_id, stall_id_ex, stall_ex_mem,
        output flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
        output muldiv_start, muldiv_timeout, ctrl_state, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing controller for the 5-stage RV32 core. Covers the
//   hazards the forwarding network cannot: load-use stalls, taken-branch
//   flushes, data-memory wait states and multi-cycle mul/div occupancy of EX.
//
//   Ports:
//     clk    core clock, all state changes on the rising edge
//     rst_n  synchronous reset, active-low
//     hz     hazard_if.slave bundle (pipeline status in, stage controls out)
//
//   Parameters:
//     CNT_W           width of the saturating stall-cycle counter (must match
//                     the CNT_W of the connected interface)
//     MULDIV_TIMEOUT  MD_BUSY cycles allowed before the watchdog fires (>= 2)
//
//   Only ctrl_state, the watchdog counter, muldiv_timeout and stall_count are
//   registered; every stage control is combinational from state and inputs so
//   the pipeline sees a hazard response in the same cycle it appears.
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int CNT_W          = 16,
    parameter int MULDIV_TIMEOUT = 64
) (
    input logic      clk,
    input logic      rst_n,
    hazard_if.slave  hz
);
    localparam int WD_W = $clog2(MULDIV_TIMEOUT + 1);
    // Watchdog fires while the counter shows the last permitted busy cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULDIV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WD_W-1:0]  wd_reg;
    logic [WD_W-1:0]  wd_next;
    logic             timeout_reg;
    logic             timeout_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    // Combinational stage controls
    logic pc_write;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
    logic muldiv_start;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic       mem_wait;
    logic       load_use;
    logic [4:0] src_reg  [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;

    assign mem_wait = hz.dmem_req_mem & ~hz.dmem_ready;

    assign src_reg[0]  = hz.rs1_id;
    assign src_reg[1]  = hz.rs2_id;
    assign src_used[0] = hz.uses_rs1_id;
    assign src_used[1] = hz.uses_rs2_id;

    // One comparator per ID source operand against the EX destination.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_used[gi] & (src_reg[gi] == hz.rd_ex);
    end

    // x0 is hard-wired to zero, so a load targeting it can never be a hazard.
    assign load_use = hz.mem_read_ex & hz.reg_write_ex &
                      (hz.rd_ex != 5'd0) & (|src_hit);

    // -------------------------------------------------------------------------
    // Output and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b1;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        muldiv_start = 1'b0;
        state_next   = state_reg;
        wd_next      = wd_reg;
        timeout_next = timeout_reg;

        if (!rst_n) begin
            // Freeze the PC and fill every stage with bubbles while in reset.
            pc_write     = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (mem_wait) begin
            // Freeze everything up to MEM; the stalled access must not retire
            // twice, so WB receives a bubble. State and watchdog hold.
            pc_write     = 1'b0;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (hz.muldiv_ex) begin
                        // Launch the unit and hold IF/ID/EX; EX/MEM gets bubbles
                        // until the result is ready.
                        muldiv_start = 1'b1;
                        pc_write     = 1'b0;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        state_next   = ST_MD_BUSY;
                        wd_next      = '0;
                    end else if (load_use) begin
                        // Hold the consumer in ID one cycle; EX gets a bubble.
                        // Next cycle the load sits in MEM and forwarding covers it.
                        pc_write     = 1'b0;
                        stall_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                    end else if (hz.branch_taken_ex) begin
                        // Squash the two wrong-path instructions; PC takes target.
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                    end
                end

                ST_MD_BUSY: begin
                    if (hz.muldiv_done) begin
                        state_next = ST_RUN;
                    end else if (wd_reg == WD_LAST) begin
                        // Give up on the unit and let the pipeline proceed; the
                        // flag stays set until reset so software can see it.
                        timeout_next = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        pc_write     = 1'b0;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        wd_next      = wd_reg + WD_W'(1);
                    end
                end

                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            wd_reg        <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
            // Saturate rather than wrap so a long run never reads as few stalls.
            if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Interface outputs
    // -------------------------------------------------------------------------
    assign hz.pc_write       = pc_write;
    assign hz.stall_if_id    = stall_if_id;
    assign hz.stall_id_ex    = stall_id_ex;
    assign hz.stall_ex_mem   = stall_ex_mem;
    assign hz.flush_if_id    = flush_if_id;
    assign hz.flush_id_ex    = flush_id_ex;
    assign hz.flush_ex_mem   = flush_ex_mem;
    assign hz.flush_mem_wb   = flush_mem_wb;
    assign hz.muldiv_start   = muldiv_start;
    assign hz.muldiv_timeout = timeout_reg;
    assign hz.ctrl_state     = state_reg;
    assign hz.stall_count    = stall_cnt_reg;

endmodule
